// File: rtl/fetch_pkg.sv
// Shared types for the multi-thread fetch unit: bus FSM states, request slot layout
// and the thread-index width helper.
package fetch_pkg;

    // Slot storage width; the unit's AW/DW must not exceed these.
    localparam int SLOT_AW = 32;
    localparam int SLOT_DW = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic               wr;
        logic [SLOT_AW-1:0] addr;
        logic [SLOT_DW-1:0] wdata;
    } slot_t;

    function automatic int tw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first pending thread after ptr (wrapping); purely combinational.
// No backpressure: grant is valid whenever any thread is pending.
module rr_arbiter #(
    parameter int THREADS = 4,
    parameter int TW      = 2
) (
    input  logic [THREADS-1:0] pending,
    input  logic [TW-1:0]      ptr,
    output logic [THREADS-1:0] grant,
    output logic [TW-1:0]      grant_idx,
    output logic               grant_vld
);

    logic [TW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = 1; i <= THREADS; i++) begin
            idx = TW'((int'(ptr) + i) % THREADS);
            if (!grant_vld && pending[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_mt_unit.sv
// Per-thread request slots serialised round-robin onto one bus master; W_STB earliest one cycle
// after acceptance, a request to an occupied slot is dropped with a req_reject pulse.
module fetch_mt_unit
    import fetch_pkg::*;
#(
    parameter int  THREADS = 4,
    parameter int  AW      = 32,
    parameter int  DW      = 32,
    parameter int  TIMEOUT = 255,
    localparam int TW      = tw(THREADS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               f_enable,
    input  logic               write_mode,
    input  logic [TW-1:0]      thread,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      data_i,
    output logic [THREADS-1:0] busy_o,
    output logic               req_reject,
    output logic               ack,
    output logic [TW-1:0]      ack_thread,
    output logic [DW-1:0]      data_o,
    output logic               err,
    output logic               W_STB,
    output logic               W_WRITE,
    output logic [AW-1:0]      W_ADDR,
    output logic [DW-1:0]      W_DATA_O,
    input  logic               W_ACK,
    input  logic [DW-1:0]      W_DATA_I
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    fetch_state_t       state_q, state_d;
    slot_t              slot_q [THREADS];
    logic [THREADS-1:0] busy_q, cur_oh, set_mask, clr_mask;
    logic [TW-1:0]      ptr_q;
    logic [CW-1:0]      cnt_q;

    logic [THREADS-1:0] gnt_oh;
    logic [TW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               accept, do_grant, do_done, do_abort, finish;

    rr_arbiter #(.THREADS(THREADS), .TW(TW)) u_arb (
        .pending   (busy_q),
        .ptr       (ptr_q),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    // Occupancy is sampled before this edge's clear, so a same-edge retry is rejected.
    assign accept   = f_enable & ~busy_q[thread];
    assign set_mask = accept ? (THREADS'(1) << thread) : '0;
    assign clr_mask = finish ? cur_oh : '0;
    assign finish   = do_done | do_abort;
    assign busy_o   = busy_q;

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_done  = 1'b0;
        do_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    do_grant = 1'b1;
                    state_d  = BUS;
                end
            end
            BUS: begin
                // A W_ACK on the limit edge still counts as a normal completion.
                if (W_ACK) begin
                    do_done = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= '0;
            cur_oh     <= '0;
            ptr_q      <= TW'(THREADS - 1);
            cnt_q      <= '0;
            req_reject <= 1'b0;
            ack        <= 1'b0;
            ack_thread <= '0;
            data_o     <= '0;
            err        <= 1'b0;
            W_STB      <= 1'b0;
            W_WRITE    <= 1'b0;
            W_ADDR     <= '0;
            W_DATA_O   <= '0;
            for (int i = 0; i < THREADS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= (busy_q | set_mask) & ~clr_mask;
            req_reject <= f_enable & busy_q[thread];
            ack        <= finish;
            err        <= do_abort;

            if (accept) begin
                slot_q[thread] <= '{wr: write_mode, addr: SLOT_AW'(addr), wdata: SLOT_DW'(data_i)};
            end

            if (do_grant) begin
                W_STB    <= 1'b1;
                W_WRITE  <= slot_q[gnt_idx].wr;
                W_ADDR   <= AW'(slot_q[gnt_idx].addr);
                W_DATA_O <= DW'(slot_q[gnt_idx].wdata);
                ptr_q    <= gnt_idx;
                cur_oh   <= gnt_oh;
                cnt_q    <= '0;
            end else if (state_q == BUS && !W_ACK && cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (finish) begin
                W_STB      <= 1'b0;
                ack_thread <= ptr_q;
                data_o     <= (do_done && !W_WRITE) ? W_DATA_I : '0;
            end
        end
    end

endmodule
